// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//   Grants one of NUM_REQ requesters access to the shared 32-bit adder. The
//   winner's operands are registered onto add_A/add_B. The sum is captured one
//   cycle later and returned with the requester ID over a valid/ready response
//   channel. Sequence per op: IDLE (grant) -> EXEC (adder settles) -> RESP
//   (hold until accepted).
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   req_valid[NUM_REQ]    per-requester request strobe
//   req_A/req_B           packed operands, requester i at [32i+31:32i]
//   req_ready[NUM_REQ]    one-hot grant, combinational, IDLE only
//   add_A/add_B           registered adder operands (hold between grants)
//   add_Result            adder sum, combinational from add_A/add_B
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_data      owner ID and registered sum (mod 2^32)
//   busy                  high outside IDLE
//
// Build option
//   ADDER_ARB_FIXED_PRI_EN  defined: lowest valid index always wins, no
//                           rotating pointer. Undefined: round-robin.
// ---------------------------------------------------------------------------

// Per-requester slice: masks the request against the rotating pointer and
// gates the operands onto the shared AND-OR select bus.
module adder_arbiter_lane (
  input  logic        valid,
  input  logic        below,   // index lies before the round-robin pointer
  input  logic        gnt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        hi,      // eligible in the "at or after ptr" pass
  output logic [31:0] a_sel,
  output logic [31:0] b_sel
);
  assign hi    = valid & ~below;
  assign a_sel = gnt ? a : '0;
  assign b_sel = gnt ? b : '0;
endmodule

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_A,
  input  logic [32*NUM_REQ-1:0] req_B,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           add_A,
  output logic [31:0]           add_B,
  input  logic [31:0]           add_Result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                        state, state_nxt;
  logic                          grant_en;
  logic                          any_vld, any_hi;
  logic [ID_W-1:0]               win, win_hi, win_lo;
  logic [ID_W-1:0]               ptr;
  logic [ID_W-1:0]               op_id;
  logic [NUM_REQ-1:0]            below, hi;
  logic [NUM_REQ-1:0][31:0]      a_term, b_term;
  logic [31:0]                   sel_a, sel_b;

  // ---- pointer mask: lanes strictly below ptr lose the first pass ----
  assign below = (NUM_REQ'(1) << ptr) - NUM_REQ'(1);

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      assign req_ready[g] = grant_en && (win == ID_W'(g));
      adder_arbiter_lane u_lane (
        .valid (req_valid[g]),
        .below (below[g]),
        .gnt   (req_ready[g]),
        .a     (req_A[32*g +: 32]),
        .b     (req_B[32*g +: 32]),
        .hi    (hi[g]),
        .a_sel (a_term[g]),
        .b_sel (b_term[g])
      );
    end
  endgenerate

  // ---- winner: lowest eligible at/after ptr, else lowest valid (wrap) ----
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (hi[i])        win_hi = ID_W'(i);
      if (req_valid[i]) win_lo = ID_W'(i);
    end
  end

  assign any_vld = |req_valid;
  assign any_hi  = |hi;
  assign win     = any_hi ? win_hi : win_lo;

  // ---- operand select: grant is one-hot, so OR-ing the gated terms is a mux ----
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a = sel_a | a_term[i];
      sel_b = sel_b | b_term[i];
    end
  end

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (any_vld) begin
          grant_en  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_A     <= '0;
      add_B     <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      // add_A/add_B only move on a grant so the adder inputs stay quiet
      if (grant_en) begin
        add_A <= sel_a;
        add_B <= sel_b;
        op_id <= win;
      end
      if (state == EXEC) begin
        rsp_data  <= add_Result;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  // ---- round-robin pointer ----
`ifdef ADDER_ARB_FIXED_PRI_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_en) begin
      ptr <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (NUM_REQ=4): table of single ops with
// hand-computed sums, then reset-mid-op, grant order, backpressure and
// withdraw sequences.
module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_A, req_B;
  logic [3:0]   req_ready;
  logic [31:0]  add_A, add_B, add_Result;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // the shared adder itself
  assign add_Result = add_A + add_B;

  adder_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_ready  (req_ready),
    .add_A      (add_A),
    .add_B      (add_B),
    .add_Result (add_Result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
    req_A[32*id +: 32] = a;
    req_B[32*id +: 32] = b;
  endtask

  // Called in IDLE at posedge+1; returns in IDLE at posedge+1.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sum, input string nm);
    logic [3:0] eg;
    eg = 4'b0001 << id;
    set_op(id, a, b);
    req_valid = eg;
    rsp_ready = 1'b1;
    #1;
    chk({nm, ".gnt"}, 32'(req_ready), 32'(eg));
    step();
    req_valid = '0;
    #1;
    chk({nm, ".exec_busy"}, 32'(busy), 32'd1);
    chk({nm, ".exec_rv"},   32'(rsp_valid), 32'd0);
    chk({nm, ".exec_rdy"},  32'(req_ready), 32'd0);
    chk({nm, ".add_A"},     add_A, a);
    chk({nm, ".add_B"},     add_B, b);
    step();
    chk({nm, ".rv"},   32'(rsp_valid), 32'd1);
    chk({nm, ".id"},   32'(rsp_id), 32'(id));
    chk({nm, ".data"}, rsp_data, sum);
    step();
    chk({nm, ".done_rv"},   32'(rsp_valid), 32'd0);
    chk({nm, ".done_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".add_A"},  add_A, 32'd0);
    chk({nm, ".add_B"},  add_B, 32'd0);
    chk({nm, ".rv"},     32'(rsp_valid), 32'd0);
    chk({nm, ".id"},     32'(rsp_id), 32'd0);
    chk({nm, ".data"},   rsp_data, 32'd0);
    chk({nm, ".rdy"},    32'(req_ready), 32'd0);
    chk({nm, ".busy"},   32'(busy), 32'd0);
  endtask

  initial begin
    int ord[5];
    logic [31:0] rr_sum[4];

    vecs[0] = '{1, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C};
    vecs[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[2] = '{3, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
    vecs[3] = '{1, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEF0};
    vecs[4] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[5] = '{2, 32'h8000_0000, 32'h8000_0001, 32'h0000_0001};

`ifdef ADDER_ARB_FIXED_PRI_EN
    ord = '{0, 0, 0, 0, 0};
`else
    ord = '{0, 1, 2, 3, 0};
`endif
    rr_sum = '{32'h0000_0100, 32'h0000_0201, 32'h0000_0302, 32'h0000_0403};

    rst_n     = 1'b0;
    req_valid = '0;
    req_A     = '0;
    req_B     = '0;
    rsp_ready = 1'b1;

    // ---- reset state ----
    #12;
    chk_zero("rst");
    step();
    rst_n = 1'b1;
    step();

    // ---- table of single ops ----
    for (int i = 0; i < 6; i++)
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));

    // ---- reset mid-EXEC ----
    set_op(1, 32'h0000_0040, 32'h0000_0002);
    req_valid = 4'b0010;
    #1;
    chk("rstmid.gnt", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    #1;
    chk("rstmid.exec", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rstmid");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rstmid.norsp", 32'(rsp_valid), 32'd0);
      step();
    end
    for (int i = 0; i < 4; i++) set_op(i, 32'h100 * (i + 1), 32'(i));
    req_valid = 4'hF;
    #1;
    chk("rstmid.gnt0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    chk("rstmid.id0", 32'(rsp_id), 32'd0);
    chk("rstmid.data0", rsp_data, 32'h0000_0100);
    step();

    // ---- all valid continuously: grant order from ptr=0 ----
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d.gnt", k), 32'(req_ready), 32'(4'b0001 << ord[k]));
      step();
      step();
      chk($sformatf("rr%0d.id", k), 32'(rsp_id), 32'(ord[k]));
      chk($sformatf("rr%0d.data", k), rsp_data, rr_sum[ord[k]]);
      step();
    end
    req_valid = '0;
    step();

    // ---- backpressure: response held, no grants while stalled ----
    set_op(2, 32'h0000_00AA, 32'h0000_0055);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    chk("bp.gnt2", 32'(req_ready), 32'h4);
    step();
    set_op(0, 32'h0000_0001, 32'h0000_0002);
    req_valid = 4'b0001;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d.rv", k),   32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d.data", k), rsp_data, 32'h0000_00FF);
      chk($sformatf("bp%0d.id", k),   32'(rsp_id), 32'd2);
      chk($sformatf("bp%0d.rdy", k),  32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp.idle_busy", 32'(busy), 32'd0);
    chk("bp.idle_rv",   32'(rsp_valid), 32'd0);
    chk("bp.gnt0",      32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    chk("bp.id0",   32'(rsp_id), 32'd0);
    chk("bp.data0", rsp_data, 32'h0000_0003);
    step();

    // ---- withdraw: req2 pulses while busy, never granted ----
    set_op(0, 32'h0000_0010, 32'h0000_0020);
    req_valid = 4'b0001;
    #1;
    chk("wd.gnt0", 32'(req_ready), 32'h1);
    step();
    set_op(2, 32'h0000_0777, 32'h0000_0001);
    req_valid = 4'b0100;
    #1;
    chk("wd.exec_rdy", 32'(req_ready), 32'd0);
    step();
    req_valid = '0;
    chk("wd.id",   32'(rsp_id), 32'd0);
    chk("wd.data", rsp_data, 32'h0000_0030);
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wd%0d.rdy", k),  32'(req_ready), 32'd0);
      chk($sformatf("wd%0d.busy", k), 32'(busy), 32'd0);
      chk($sformatf("wd%0d.rv", k),   32'(rsp_valid), 32'd0);
      chk($sformatf("wd%0d.holdA", k), add_A, 32'h0000_0010);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
